// File: rtl/serial_pkg.sv
// Shared definitions for the buffered COM port: TX pacing states and status register layout.
package serial_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_GUARD = 2'd2
  } tx_state_t;

  localparam int ST_TXRDY  = 0;
  localparam int ST_RXAVL  = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_TXIDLE = 3;
  localparam int ST_TXIE   = 4;

  localparam int RXCNT_LSB = 8;
  localparam int TXCNT_LSB = 16;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO; push-when-full (without a same-cycle pop) and pop-when-empty are ignored.
module sync_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/serial_fifo_ctrl.sv
// Buffered COM port: RX/TX byte FIFOs, TX pacing FSM, overrun flag and COM interrupt.
// Optional macro SERIAL_TX_INT_EN adds a txIntEn control bit so TX-idle also raises int_o.
module serial_fifo_ctrl
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output tx_state_t   tx_state_dbg
);

  logic                data_rd, data_wr, status_rd;
  logic [7:0]          rx_dout, tx_dout;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic                tx_pop, tx_idle, overrun, txie;
  logic [31:0]         status;
  tx_state_t           state, state_nxt;

  assign data_rd   = enable_i &  readEnable_i & ~mode_i;
  assign data_wr   = enable_i & ~readEnable_i & ~mode_i;
  assign status_rd = enable_i &  readEnable_i &  mode_i;

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rxdReady_i), .pop(data_rd), .din(rxdData_i),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(data_wr), .pop(tx_pop), .din(dataSave_i[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!tx_empty && !txdBusy_i) begin
          tx_pop    = 1'b1;
          state_nxt = TX_START;
        end
      end
      TX_START: state_nxt = TX_GUARD;
      // Gives the transmitter a cycle to raise busy before the next start is considered.
      TX_GUARD: state_nxt = TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TX_IDLE;
      txdData_o <= 8'h00;
    end else begin
      state <= state_nxt;
      if (tx_pop) txdData_o <= tx_dout;
    end
  end

  assign txdStart_o   = (state == TX_START);
  assign tx_state_dbg = state;
  assign tx_idle      = tx_empty & (state == TX_IDLE);

`ifdef SERIAL_TX_INT_EN
  always_ff @(posedge clk) begin
    if (rst) txie <= 1'b0;
    else if (enable_i && !readEnable_i && mode_i) txie <= dataSave_i[0];
  end
`else
  assign txie = 1'b0;
`endif

  logic unused_hi;
  assign unused_hi = ^dataSave_i[31:8];

  // Set wins over the clear from a status read in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else if (rxdReady_i && rx_full && !data_rd) overrun <= 1'b1;
    else if (status_rd) overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) int_o <= 1'b0;
    else     int_o <= ~rx_empty | (txie & tx_idle);
  end

  always_comb begin
    status                         = '0;
    status[ST_TXRDY]               = ~tx_full;
    status[ST_RXAVL]               = ~rx_empty;
    status[ST_OVR]                 = overrun;
    status[ST_TXIDLE]              = tx_idle;
    status[ST_TXIE]                = txie;
    status[RXCNT_LSB +: CNT_W]     = CNT_W'(rx_count);
    status[TXCNT_LSB +: CNT_W]     = CNT_W'(tx_count);
  end

  always_comb begin
    dataLoad_o = 32'h0;
    if (status_rd)                dataLoad_o = status;
    else if (data_rd && !rx_empty) dataLoad_o = {24'h0, rx_dout};
  end

endmodule
